jpeg_bitpack: RTL
=================

# jpeg_bitpack

Final stage of `jpeg_pipeline`. It takes variable-length entropy codes from the Huffman coder and packs them MSB-first into a byte stream. It applies JPEG byte stuffing (0x00 after every 0xFF) and emits 16-bit words with per-byte valid flags to the DMA controller, which writes them to memory. On flush it pads the final partial byte with 1s and marks the last beat so the controller can finish the image and raise its interrupt.

## Interface
Parameters:
- none (widths fixed by the JPEG format: max code 16 bits + 11 amplitude bits = 27).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high; clock clk
- in_valid  in  1  code present on `in_bits`/`in_len`/`in_flush`
- in_ready  out  1  block can accept a code this cycle
- in_bits  in  27  code, right-aligned; bits above `in_len` ignored
- in_len  in  5  code length 0..27; values 28..31 are illegal (behaviour undefined)
- in_flush  in  1  last code of image; drain and pad after this code
- out_ena  out  1  output beat valid
- out_rdy  in  1  downstream accepts beat (transfer when `out_ena && out_rdy`)
- out_bits  out  16  first stream byte in [15:8], second in [7:0]
- out_valid  out  2  byte enables: 2'b11 full word, 2'b10 only [15:8], 2'b00 empty terminator
- done_flush  out  1  this beat is the last of the image

## Operation
- Accumulator: 40-bit bit buffer `acc` plus 6-bit count `cnt`. Bits are MSB-aligned.
- Accept: `in_ready = (cnt <= 13) && state==RUN`. On `in_valid && in_ready`, append the low `in_len` bits below the existing bits, and set `cnt += in_len`. `in_len=0` is legal (used with `in_flush` alone).
- `in_flush` accepted: latch `flush_pend` and deassert `in_ready` until the terminator beat transfers.
- Byte stage: moves at most one byte per cycle into the word register, when the word register has a free slot.
  - If `stuff_pend` is set, insert 0x00 and clear `stuff_pend`.
  - Else if `cnt >= 8`, take the top byte and set `cnt -= 8`. If that byte is 0xFF, set `stuff_pend`.
- Word register: holds 0–2 bytes.
  - With 2 bytes: `out_ena=1`, `out_valid=2'b11`.
  - If a beat transfers and the byte stage writes in the same cycle, the new byte goes to slot [15:8].
- States:
  - RUN: normal operation. Go to PAD when `flush_pend && cnt < 8 && !stuff_pend` and the byte stage is idle.
  - PAD: if `cnt` is 1..7, form a byte of the remaining bits with 1s in the low positions, set `cnt=0`, and stuff if the result is 0xFF. Then go to FINAL once all bytes, including any stuffed 0x00, are in the word register.
  - FINAL: present the remaining word with `done_flush=1`.
    - One byte held: `out_valid=2'b10`.
    - Two bytes held: 2'b11.
    - Zero bytes held: 2'b00 with `out_bits=0`.
    - On transfer, clear `acc`, `cnt`, `flush_pend` and the word register, and go to RUN.
  - A full word that becomes ready during PAD is sent as a normal beat first, with `done_flush=0`.
- `done_flush` is asserted only in the FINAL beat. Exactly one terminator beat is sent per flush.

## Timing
- Reset values: `in_ready=1`, `out_ena=0`, `out_valid=2'b00`, `out_bits=16'h0`, `done_flush=0`, state RUN, `cnt=0`, `stuff_pend=0`, `flush_pend=0`.
- `rst` mid-image discards all buffered bits and any beat on hold, with no terminator beat.
- Latency, empty block with `out_rdy=1`: a 16-bit code accepted in cycle N gives bytes moved at the edges ending N+1 and N+2, and `out_ena=1` in cycle N+3.
- Throughput: one byte per cycle. Stuffing costs one extra byte slot.
- Hold rules while `out_ena=1 && !out_rdy`:
  - `out_bits`, `out_valid` and `done_flush` stay stable, and `out_ena` stays high.
  - The byte stage stalls when the word register is full.
  - `in_ready` still follows the `cnt` rule.
- `in_ready` depends on registered state only. Upstream may hold `in_valid` arbitrarily.
- Simultaneous accept and byte extract in one cycle: `cnt_next = cnt + in_len - 8`.

## Test plan
- Reset: hold `rst` 2 cycles -> `in_ready=1`, `out_ena=0`, `out_valid=00`, `done_flush=0`.
- Codes 8'hAB (len 8) then 8'hCD (len 8), `out_rdy=1` -> one beat `out_bits=16'hABCD`, `out_valid=11`, `done_flush=0`, first `out_ena` 3 cycles after the first accept.
- Stuffing: 8'hFF len 8, 8'h12 len 8, then len 0 with `in_flush`.
  - Beat 1: 16'hFF00, valid 11.
  - Beat 2: 16'h12xx, valid 10, `done_flush=1`.
- Padding: 3'b101 len 3 with `in_flush` -> single beat 16'hBFxx, valid 10, `done_flush=1`. Then 7'h7F len 7 with `in_flush` -> 16'hFF00, valid 11, `done_flush=1` (pad creates 0xFF, which is stuffed).
- Empty flush: len 0 with `in_flush` right after reset -> one beat, valid 00, `done_flush=1`, then `in_ready` returns to 1.
- Backpressure: 40 random codes, `out_rdy` toggled randomly.
  - Beats stay stable while held, with no loss or duplication.
  - The reassembled stream with stuffing removed matches a reference bit concatenation padded with 1s.
  - `in_ready=0` whenever `cnt > 13`.

Source files
------------

// File: rtl/jpeg_bitpack_if.sv
// jpeg_bitpack_if: entropy-code input and 16-bit beat output handshakes of the bit packer
interface jpeg_bitpack_if;
    logic        in_valid;
    logic        in_ready;
    logic [26:0] in_bits;
    logic [4:0]  in_len;
    logic        in_flush;
    logic        out_ena;
    logic        out_rdy;
    logic [15:0] out_bits;
    logic [1:0]  out_valid;
    logic        done_flush;
    modport master (
        output in_valid, in_bits, in_len, in_flush, out_rdy,
        input  in_ready, out_ena, out_bits, out_valid, done_flush
    );
    modport slave (
        input  in_valid, in_bits, in_len, in_flush, out_rdy,
        output in_ready, out_ena, out_bits, out_valid, done_flush
    );
endinterface

// File: rtl/jpeg_bitpack.sv
// jpeg_bitpack: packs variable-length codes MSB-first into stuffed 16-bit beats with 1-padded flush
module jpeg_bitpack (
    input logic           clk,
    input logic           rst,
    jpeg_bitpack_if.slave bp
);
    typedef enum logic [1:0] {RUN, PAD, FINAL} state_t;
    state_t      state_q, state_d;
    logic [39:0] acc_q, acc_d, acc_s;
    logic [5:0]  cnt_q, cnt_d, cnt_s;
    logic        stuff_q, stuff_d;
    logic        flush_q, flush_d;
    logic [15:0] word_q, word_d, word_x;
    logic [1:0]  wcnt_q, wcnt_d, wcnt_x;
    logic        xfer, accept, fin, slot_free;
    logic        take_stuff, take_byte, take_pad, mv;
    logic [7:0]  byte_v;
    logic [26:0] code;
    logic [6:0]  sh;

    assign bp.in_ready   = state_q == RUN && !flush_q && cnt_q <= 6'd13;
    assign bp.out_ena    = wcnt_q == 2'd2 || state_q == FINAL;
    assign bp.out_valid  = wcnt_q == 2'd2 ? 2'b11 : (state_q == FINAL && wcnt_q == 2'd1) ? 2'b10 : 2'b00;
    assign bp.out_bits   = word_q;
    assign bp.done_flush = state_q == FINAL;

    // Byte stage, code append, word register fill and RUN/PAD/FINAL sequencing
    always_comb begin
        xfer       = bp.out_ena && bp.out_rdy;
        accept     = bp.in_valid && bp.in_ready;
        fin        = state_q == FINAL && xfer;
        slot_free  = wcnt_q != 2'd2 || xfer;
        take_stuff = stuff_q;
        take_byte  = !stuff_q && cnt_q >= 6'd8;
        take_pad   = state_q == PAD && !stuff_q && cnt_q != 6'd0 && cnt_q < 6'd8;
        mv         = slot_free && state_q != FINAL && (take_stuff || take_byte || take_pad);
        byte_v     = take_stuff ? 8'h00 : take_byte ? acc_q[39:32] : acc_q[39:32] | (8'hFF >> cnt_q[2:0]);
        acc_s      = mv && !take_stuff ? acc_q << 8 : acc_q;
        cnt_s      = mv && take_byte ? cnt_q - 6'd8 : mv && take_pad ? 6'd0 : cnt_q;
        stuff_d    = mv ? !take_stuff && byte_v == 8'hFF : stuff_q;
        code       = bp.in_bits & ~(27'h7FF_FFFF << bp.in_len);
        sh         = 7'd40 - {1'b0, cnt_s} - {2'b0, bp.in_len};
        acc_d      = fin ? 40'h0 : accept ? acc_s | ({13'b0, code} << sh) : acc_s;
        cnt_d      = fin ? 6'd0 : accept ? cnt_s + {1'b0, bp.in_len} : cnt_s;
        flush_d    = !fin && (flush_q || (accept && bp.in_flush));
        wcnt_x     = xfer ? 2'd0 : wcnt_q;
        word_x     = xfer ? 16'h0 : word_q;
        word_d     = !mv ? word_x : wcnt_x == 2'd0 ? {byte_v, 8'h00} : {word_x[15:8], byte_v};
        wcnt_d     = wcnt_x + {1'b0, mv};
        state_d    = state_q == RUN && flush_q && cnt_q < 6'd8 && !stuff_q ? PAD :
                     state_q == PAD && cnt_s == 6'd0 && !stuff_d ? FINAL :
                     fin ? RUN : state_q;
    end

    // State registers; reset drops all buffered bits and any held beat
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            acc_q   <= '0;
            cnt_q   <= '0;
            stuff_q <= 1'b0;
            flush_q <= 1'b0;
            word_q  <= '0;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            stuff_q <= stuff_d;
            flush_q <= flush_d;
            word_q  <= word_d;
            wcnt_q  <= wcnt_d;
        end
    end
endmodule
